derrida_collector: RTL and testbench
====================================

// Module: derrida_collector
// PURPOSE
//   Sink for the GRN next-state stream. Captures one successor state per input state (stream order = state
//   index 0..2^N_GENES-1, as emitted by the producer->grn chain), then scans every (state, single-bit-flip
//   neighbour) pair, histograms Hamming distance between their successors (Derrida, d0=1), streams bins out.
// PARAMETERS
//   N_GENES  5   number of genes = state width; table depth 2^N_GENES
//   CNT_W    16  histogram bin counter width
// PORTS
//   clk                in   1        clock, rising edge
//   rst_n              in   1        asynchronous reset, active low
//   input_data_valid   in   1        successor sample valid (grn output_data_valid)
//   input_data         in   N_GENES  successor state (grn output_data)
//   out_valid          out  1        histogram bin presented
//   out_ready          in   1        sink accepts bin when out_valid & out_ready
//   out_bin            out  $clog2(N_GENES+1)  Hamming distance of bin (0..N_GENES)
//   out_count          out  CNT_W    pair count for out_bin
//   done               out  1        all bins delivered; sticky until reset
// BEHAVIOUR
//   - Reset (async assert, sync-released use): state=COLLECT, wr_idx=0, scan s=0,b=0, all bins=0,
//     out_valid=0, out_bin=0, out_count=0, done=0. Table contents undefined, never read before written.
//   - FSM COLLECT -> SCAN -> EMIT -> DONE.
//   - COLLECT: each cycle with input_data_valid=1 writes table[wr_idx]=input_data, wr_idx++. Gaps in
//     valid stall the index. Write at wr_idx=2^N-1 moves to SCAN next cycle.
//   - SCAN: one (s,b) pair per cycle, b inner (0..N-1), s outer (0..2^N-1). Two combinational table reads:
//     table[s], table[s ^ (1<<b)]; hd = popcount(xor); bins[hd] += 1, saturating at 2^CNT_W-1.
//     Accumulate registered same cycle; last pair (s=2^N-1,b=N-1) -> EMIT. Scan = N*2^N cycles (160 default).
//   - EMIT: out_valid=1, out_bin=k, out_count=bins[k], k from 0 to N. k advances only on out_valid&out_ready;
//     out_bin/out_count held stable while out_ready=0. Handshake on k=N -> DONE, out_valid=0 next cycle.
//   - DONE: done=1, out_valid=0; block inert until reset.
//   - input_data_valid while in SCAN/EMIT/DONE: ignored, table not written.
//   - Reset mid-operation: immediate return to reset values; partial histogram discarded.
//   - Sum of bins (no saturation, macro off) = N*2^N exactly.
// CONFIGURATION
//   DERRIDA_SYMM_EN defined: pair accumulated only when bit b of s is 0 (each unordered pair once);
//     scan cycle count unchanged, bin sum = N*2^(N-1) (80 default).
//   Undefined: every ordered pair accumulated; each unordered pair counted twice, sum = N*2^N.
// STRUCTURE
//   Shared package: FSM state encoding (COLLECT/SCAN/EMIT/DONE), bin-index width function,
//   saturating-increment constant. One sub-module: derrida_popcount (N_GENES-bit combinational
//   popcount, output width $clog2(N_GENES+1)). Table = 2^N x N register array inside top.
// TESTING
//   1 Identity map (sample i = i, 32 samples) -> bins {0:0,1:160,2..5:0}; done after 6 accepts.
//   2 Constant map (all samples 5'b00000) -> bin0=160, others 0.
//   3 Valid gaps: 32 identity samples with valid low 3 cycles every 4th -> same result as test 1.
//   4 out_ready low 10 cycles during bin 1 -> out_bin=1, out_count=160 held stable, no bin skipped.
//   5 rst_n pulsed low at scan cycle 50, then full identity stream -> bins exactly as test 1, no residue.
//   6 DERRIDA_SYMM_EN with identity map -> bin1=80; extra valid samples during SCAN change nothing.

Source files
------------

// File: rtl/derrida_collector_pkg.sv
// Shared types and helpers for the Derrida collector: FSM encoding, bin-index widths,
// saturating increment step.
package derrida_collector_pkg;

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StScan    = 2'd1,
        StEmit    = 2'd2,
        StDone    = 2'd3
    } state_t;

    localparam int unsigned SAT_INC = 1;

    // Width needed to hold a Hamming distance 0..n_genes.
    function automatic int unsigned bin_w(input int unsigned n_genes);
        return $clog2(n_genes + 1);
    endfunction

    // Width of the flipped-bit index, never zero.
    function automatic int unsigned idx_w(input int unsigned n_genes);
        return (n_genes > 1) ? $clog2(n_genes) : 1;
    endfunction

endpackage

// File: rtl/derrida_collector_if.sv
// Successor-sample input stream plus histogram-bin output handshake for derrida_collector.
interface derrida_collector_if #(
    parameter int unsigned N_GENES = 5,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned BIN_W = derrida_collector_pkg::bin_w(N_GENES);

    logic               input_data_valid;
    logic [N_GENES-1:0] input_data;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   out_bin;
    logic [CNT_W-1:0]   out_count;
    logic               done;

    modport master (
        output input_data_valid, input_data, out_ready,
        input  out_valid, out_bin, out_count, done
    );

    modport slave (
        input  input_data_valid, input_data, out_ready,
        output out_valid, out_bin, out_count, done
    );

endinterface

// File: rtl/derrida_popcount.sv
// Combinational population count of an N_GENES-bit vector.
module derrida_popcount #(
    parameter int unsigned N_GENES = 5,
    parameter int unsigned OUT_W   = $clog2(N_GENES + 1)
) (
    input  logic [N_GENES-1:0] i_vec,
    output logic [OUT_W-1:0]   o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N_GENES; i++) begin
            o_cnt = o_cnt + OUT_W'(i_vec[i]);
        end
    end

endmodule

// File: rtl/derrida_collector.sv
// Collects a 2^N successor table, histograms successor Hamming distance over single-bit-flip
// neighbour pairs and streams the bins out. DERRIDA_SYMM_EN counts each unordered pair once.
module derrida_collector
    import derrida_collector_pkg::*;
#(
    parameter int unsigned N_GENES = 5,
    parameter int unsigned CNT_W   = 16
) (
    input logic          clk,
    input logic          rst_n,
    derrida_collector_if.slave bus
);

    localparam int unsigned      DEPTH   = 2 ** N_GENES;
    localparam int unsigned      BIN_W   = bin_w(N_GENES);
    localparam int unsigned      IDX_W   = idx_w(N_GENES);
    localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(N_GENES - 1);
    localparam logic [BIN_W-1:0] LAST_K  = BIN_W'(N_GENES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    logic [N_GENES-1:0] r_wr_idx;
    logic [N_GENES-1:0] r_s;
    logic [IDX_W-1:0]   r_b;
    logic [BIN_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_bins [N_GENES+1];
    logic               r_out_valid;
    logic [BIN_W-1:0]   r_out_bin;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_done;
    logic [N_GENES-1:0] r_table [DEPTH];

    logic [N_GENES-1:0] w_partner;
    logic [N_GENES-1:0] w_diff;
    logic [BIN_W-1:0]   w_hd;
    logic [BIN_W-1:0]   w_k_next;
    logic               w_acc;
    logic               w_write;
    logic [CNT_W-1:0]   w_bins_upd [N_GENES+1];

    assign w_write   = (r_state == StCollect) && bus.input_data_valid;
    assign w_partner = r_s ^ (N_GENES'(1) << r_b);
    assign w_diff    = r_table[r_s] ^ r_table[w_partner];
    assign w_k_next  = r_k + BIN_W'(1);

`ifdef DERRIDA_SYMM_EN
    assign w_acc = ~r_s[r_b];
`else
    assign w_acc = 1'b1;
`endif

    derrida_popcount #(
        .N_GENES (N_GENES),
        .OUT_W   (BIN_W)
    ) u_popcount (
        .i_vec (w_diff),
        .o_cnt (w_hd)
    );

    // Histogram after this cycle's pair; also feeds bin 0 straight into the first EMIT beat.
    always_comb begin
        for (int k = 0; k < N_GENES + 1; k++) begin
            w_bins_upd[k] = r_bins[k];
            if (w_acc && (w_hd == BIN_W'(k)) && (r_bins[k] != CNT_MAX)) begin
                w_bins_upd[k] = r_bins[k] + CNT_W'(SAT_INC);
            end
        end
    end

    // Table storage carries no reset: every entry is written before the scan reads it.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_table[r_wr_idx] <= bus.input_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StCollect;
            r_wr_idx    <= '0;
            r_s         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            for (int k = 0; k < N_GENES + 1; k++) begin
                r_bins[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_count <= '0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (bus.input_data_valid) begin
                        r_wr_idx <= r_wr_idx + N_GENES'(1);
                        if (r_wr_idx == N_GENES'(DEPTH - 1)) begin
                            r_state <= StScan;
                        end
                    end
                end
                StScan: begin
                    for (int k = 0; k < N_GENES + 1; k++) begin
                        r_bins[k] <= w_bins_upd[k];
                    end
                    if (r_b == LAST_B) begin
                        r_b <= '0;
                        r_s <= r_s + N_GENES'(1);
                        if (r_s == N_GENES'(DEPTH - 1)) begin
                            r_state     <= StEmit;
                            r_out_valid <= 1'b1;
                            r_out_bin   <= '0;
                            r_out_count <= w_bins_upd[0];
                        end
                    end else begin
                        r_b <= r_b + IDX_W'(1);
                    end
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        if (r_k == LAST_K) begin
                            r_state     <= StDone;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_k         <= w_k_next;
                            r_out_bin   <= w_k_next;
                            r_out_count <= r_bins[w_k_next];
                        end
                    end
                end
                StDone: begin
                end
                default: begin
                    r_state <= StCollect;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_bin   = r_out_bin;
    assign bus.out_count = r_out_count;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_derrida_collector.sv
// Self-checking bench for derrida_collector: vector table plus scoreboard of expected bins.
`timescale 1ns/1ps
module tb_derrida_collector;

    localparam int N     = 5;
    localparam int DEPTH = 32;
    localparam int CW    = 16;
`ifdef DERRIDA_SYMM_EN
    localparam logic [15:0] FULL = 16'(N * DEPTH / 2);
`else
    localparam logic [15:0] FULL = 16'(N * DEPTH);
`endif

    typedef struct packed {
        logic [1:0]  kind;       // 0 identity, 1 constant zero, 2 random map
        logic        gaps;
        logic [3:0]  stall_bin;  // >N means no stall
        logic        extra;
        logic        use_model;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    typedef struct packed {
        logic [2:0]  bin;
        logic [15:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [4:0] m [DEPTH];
    vec_t vecs [6];
    exp_t sb [$];

    always #5 clk = ~clk;

    derrida_collector_if #(.N_GENES(N), .CNT_W(CW)) bus ();

    derrida_collector #(.N_GENES(N), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.input_data_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_bin", int'(bus.out_bin), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_map(input logic [1:0] kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                2'd0:    m[i] = 5'(i);
                2'd1:    m[i] = 5'd0;
                default: m[i] = 5'($urandom);
            endcase
        end
    endtask

    task automatic push_expected(input vec_t v);
        int h [N+1];
        for (int k = 0; k <= N; k++) h[k] = 0;
        if (v.use_model) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int b = 0; b < N; b++) begin
`ifdef DERRIDA_SYMM_EN
                    if (((s >> b) & 1) == 0)
`endif
                    h[$countones(m[s] ^ m[s ^ (1 << b)])]++;
                end
            end
        end else begin
            h[0] = int'(v.exp0);
            h[1] = int'(v.exp1);
        end
        for (int k = 0; k <= N; k++) sb.push_back('{bin: 3'(k), cnt: 16'(h[k])});
    endtask

    task automatic stream(input logic gaps);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps && (i % 4 == 3)) begin
                repeat (3) begin
                    @(negedge clk);
                    bus.input_data_valid = 1'b0;
                    bus.input_data = 5'($urandom);
                end
            end
            @(negedge clk);
            bus.input_data_valid = 1'b1;
            bus.input_data = m[i];
        end
    endtask

    // Last sample written at the edge after its drive; 160 scan edges later out_valid rises,
    // first visible 161 negedges after the drive.
    task automatic wait_emit(input logic extra, output logic ok);
        int cyc;
        cyc = 0;
        ok = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (extra && cyc <= 6) begin
                bus.input_data_valid = 1'b1;
                bus.input_data = 5'($urandom);
            end else begin
                bus.input_data_valid = 1'b0;
            end
        end
        bus.input_data_valid = 1'b0;
        if (!ok) check("emit_timeout", 0, 1);
        else begin
            check("scan_latency", cyc, 161);
            check("done_before_emit", int'(bus.done), 0);
        end
    endtask

    task automatic drain(input int stall_bin);
        int accepts, stall, cyc;
        exp_t e;
        accepts = 0;
        stall = 0;
        cyc = 0;
        while (accepts < N + 1 && cyc < 200) begin
            cyc++;
            if (!bus.out_valid) begin
                check("valid_dropped", 0, 1);
                bus.out_ready = 1'b0;
            end else if (int'(bus.out_bin) == stall_bin && stall < 10) begin
                if (sb.size() > 0) begin
                    check("hold_bin", int'(bus.out_bin), int'(sb[0].bin));
                    check("hold_count", int'(bus.out_count), int'(sb[0].cnt));
                end
                stall++;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'b1;
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("bin", int'(bus.out_bin), int'(e.bin));
                    check("count", int'(bus.out_count), int'(e.cnt));
                end
                accepts++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("accepts", accepts, N + 1);
        check("valid_after_done", int'(bus.out_valid), 0);
        check("done", int'(bus.done), 1);
        if (stall_bin <= N) check("stall_cycles", stall, 10);
    endtask

    task automatic run_body(input vec_t v);
        logic ok;
        sb.delete();
        fill_map(v.kind);
        push_expected(v);
        stream(v.gaps);
        wait_emit(v.extra, ok);
        if (ok) drain(int'(v.stall_bin));
        sb.delete();
    endtask

    initial begin
        bus.input_data_valid = 1'b0;
        bus.input_data = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{2'd0, 1'b0, 4'd15, 1'b0, 1'b0, 16'd0, FULL};
        vecs[1] = '{2'd1, 1'b0, 4'd15, 1'b0, 1'b0, FULL, 16'd0};
        vecs[2] = '{2'd0, 1'b1, 4'd15, 1'b0, 1'b0, 16'd0, FULL};
        vecs[3] = '{2'd0, 1'b0, 4'd1,  1'b0, 1'b0, 16'd0, FULL};
        vecs[4] = '{2'd0, 1'b0, 4'd15, 1'b1, 1'b0, 16'd0, FULL};
        vecs[5] = '{2'd2, 1'b1, 4'd2,  1'b1, 1'b1, 16'd0, 16'd0};

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            run_body(vecs[i]);
        end

        // DONE is inert: traffic on both sides changes nothing.
        bus.input_data_valid = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.input_data_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("done_sticky", int'(bus.done), 1);
        check("done_no_valid", int'(bus.out_valid), 0);

        // Reset partway through the scan, then a clean identity run must show no residue.
        apply_reset();
        fill_map(2'd0);
        stream(1'b0);
        @(negedge clk);
        bus.input_data_valid = 1'b0;
        repeat (49) @(negedge clk);
        apply_reset();
        run_body(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
